// File: rtl/mux_rr_arb.sv
// rtl/mux_rr_arb.sv - N-input arbitrating mux with round-robin or fixed select and a registered 1-entry output
// A new item loads whenever the output is empty or being drained in the same cycle.
module mux_rr_arb #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               MODE,
   input  logic [SEL_W-1:0]   SEL,
   input  logic [N*WIDTH-1:0] IN_DATA,
   input  logic [N-1:0]       IN_VALID,
   output logic [N-1:0]       IN_READY,
   output logic [WIDTH-1:0]   OUT_DATA,
   output logic [SEL_W-1:0]   OUT_SEL,
   output logic               OUT_VALID,
   input  logic               OUT_READY
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] gnt;
   logic [SEL_W-1:0] scan_idx;
   logic             gnt_vld;
   logic             load;
   int               idx;
   logic [WIDTH-1:0] ch_data [N];

   for (genvar i = 0; i < N; i++) begin : g_split
      assign ch_data[i] = IN_DATA[i*WIDTH +: WIDTH];
   end

   assign load = (state == EMPTY) | OUT_READY;

   // Round-robin scans upward from ptr with wrap; fixed mode only looks at SEL.
   always_comb begin
      gnt      = '0;
      gnt_vld  = 1'b0;
      idx      = 0;
      scan_idx = '0;
      if (MODE) begin
         if (int'(SEL) < N) begin
            if (IN_VALID[SEL]) begin
               gnt     = SEL;
               gnt_vld = 1'b1;
            end
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            scan_idx = SEL_W'(idx);
            if (!gnt_vld && IN_VALID[scan_idx]) begin
               gnt     = scan_idx;
               gnt_vld = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (load) state_nxt = gnt_vld ? FULL : EMPTY;
   end

   always_comb begin
      IN_READY  = '0;
      OUT_VALID = (state == FULL);
      if (!RST && load && gnt_vld) IN_READY[gnt] = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_DATA <= '0;
         OUT_SEL  <= '0;
         ptr      <= '0;
      end else if (load && gnt_vld) begin
         OUT_DATA <= ch_data[gnt];
         OUT_SEL  <= gnt;
         if (!MODE) begin
            if (int'(gnt) == N - 1) ptr <= '0;
            else                    ptr <= gnt + SEL_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb/tb_mux_rr_arb.sv - randomized and directed bench for mux_rr_arb against a behavioural model
module tb_mux_rr_arb;
   localparam int N = 4;
   localparam int W = 32;
   localparam logic [31:0] BASE = 32'd1431655700;

   logic           CLK = 1'b0;
   logic           RST;
   logic           MODE;
   logic [1:0]     SEL;
   logic [N*W-1:0] IN_DATA;
   logic [N-1:0]   IN_VALID;
   logic [N-1:0]   IN_READY;
   logic [W-1:0]   OUT_DATA;
   logic [1:0]     OUT_SEL;
   logic           OUT_VALID;
   logic           OUT_READY;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model of the output buffer and rotation pointer
   logic        m_valid;
   logic [31:0] m_data;
   int          m_sel;
   int          m_ptr;

   mux_rr_arb #(.WIDTH(W), .N(N), .SEL_W(2)) dut (
      .CLK(CLK), .RST(RST), .MODE(MODE), .SEL(SEL), .IN_DATA(IN_DATA),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OUT_DATA(OUT_DATA),
      .OUT_SEL(OUT_SEL), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick_grant();
      int g = -1;
      if (MODE) begin
         if (int'(SEL) < N && IN_VALID[SEL]) g = int'(SEL);
      end else begin
         for (int k = 0; k < N; k++)
            if (g < 0 && IN_VALID[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      return g;
   endfunction

   // Called at the falling edge with inputs already applied; checks, then advances one clock.
   task automatic step();
      int          g;
      logic        load;
      logic [3:0]  exp_ready;
      #1;
      g = pick_grant();
      load = !m_valid || OUT_READY;
      exp_ready = (!RST && load && g >= 0) ? 4'(1 << g) : 4'b0000;
      check("in_ready", 64'(IN_READY), 64'(exp_ready));
      check("out_valid", 64'(OUT_VALID), 64'(m_valid));
      check("out_data", 64'(OUT_DATA), 64'(m_data));
      check("out_sel", 64'(OUT_SEL), 64'(m_sel));
      @(posedge CLK);
      if (RST) begin
         m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
      end else if (load) begin
         if (g >= 0) begin
            m_valid = 1;
            m_data  = IN_DATA[g*W +: W];
            m_sel   = g;
            if (!MODE) m_ptr = (g + 1) % N;
         end else begin
            m_valid = 0;
         end
      end
      @(negedge CLK);
   endtask

   initial begin
      RST = 1; MODE = 0; SEL = 0; IN_VALID = 4'b1111; OUT_READY = 1;
      for (int i = 0; i < N; i++) IN_DATA[i*W +: W] = BASE + 32'(i);
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
      @(posedge CLK);
      @(negedge CLK);

      // reset held with all inputs valid
      step();
      step();
      check("rst_out_valid", 64'(OUT_VALID), 64'd0);
      check("rst_out_data", 64'(OUT_DATA), 64'd0);
      check("rst_in_ready", 64'(IN_READY), 64'd0);
      RST = 0;

      // fixed select
      MODE = 1;
      for (int s = 0; s < N; s++) begin
         SEL = 2'(s);
         step();
         check("fixed_data", 64'(OUT_DATA), 64'(BASE + 32'(s)));
         check("fixed_sel", 64'(OUT_SEL), 64'(s));
      end

      // full round-robin with wrap
      MODE = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("rr_onehot", 64'($onehot(IN_READY)), 64'd1);
         step();
         check("rr_sel", 64'(OUT_SEL), 64'(k % 4));
      end

      // sparse requesters, then only ch1
      IN_VALID = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         step();
         check("sparse_sel", 64'(OUT_SEL), (k % 2 == 0) ? 64'd1 : 64'd3);
      end
      IN_VALID = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         step();
         check("single_sel", 64'(OUT_SEL), 64'd1);
      end

      // backpressure holds ch1's item; ch2 loads once drained
      IN_VALID = 4'b1111;
      OUT_READY = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("stall_ready", 64'(IN_READY), 64'd0);
         step();
         check("stall_data", 64'(OUT_DATA), 64'(BASE + 32'd1));
         check("stall_valid", 64'(OUT_VALID), 64'd1);
      end
      OUT_READY = 1;
      step();
      check("resume_sel", 64'(OUT_SEL), 64'd2);
      check("resume_data", 64'(OUT_DATA), 64'(BASE + 32'd2));

      // reset while ch2 is being offered
      IN_VALID = 4'b0100;
      RST = 1;
      step();
      check("midrst_valid", 64'(OUT_VALID), 64'd0);
      RST = 0;
      IN_VALID = 4'b1111;
      #1;
      check("postrst_ready", 64'(IN_READY), 64'b0001);
      step();
      check("postrst_sel", 64'(OUT_SEL), 64'd0);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         RST       = ($urandom_range(0, 99) == 0);
         MODE      = ($urandom_range(0, 3) == 0);
         SEL       = 2'($urandom);
         IN_VALID  = 4'($urandom);
         OUT_READY = ($urandom_range(0, 3) != 0);
         IN_DATA   = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
